// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the pc_ctrl front-end: FSM encodings, NOP word,
// default reset PC and the word-alignment helper.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    STATE_BOOT     = 2'd0,
    STATE_RUN      = 2'd1,
    STATE_REDIRECT = 2'd2,
    STATE_HOLD     = 2'd3
  } state_e;

  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          FLUSH_CNT_W      = 3;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// Execute-to-front-end control bus: redirect/hold requests in, fetch request
// and pipeline flush/stall out. pc_ctrl sits on the slave side.
interface pc_ctrl_if;

  logic [31:0] jump_addr_i;
  logic        jump_en_i;
  logic        hold_flag_i;
  logic        fetch_ready_i;
  logic [31:0] pc_o;
  logic        fetch_valid_o;
  logic        flush_o;
  logic        stall_o;
  logic        misalign_o;

  modport master (
    output jump_addr_i, jump_en_i, hold_flag_i, fetch_ready_i,
    input  pc_o, fetch_valid_o, flush_o, stall_o, misalign_o
  );

  modport slave (
    input  jump_addr_i, jump_en_i, hold_flag_i, fetch_ready_i,
    output pc_o, fetch_valid_o, flush_o, stall_o, misalign_o
  );

endinterface

// File: rtl/pc_ctrl_flush_counter.sv
// Loadable down-counter that times the post-jump flush window; saturates at 0.
module pc_ctrl_flush_counter
  import pc_ctrl_pkg::*;
#(
  parameter int W = FLUSH_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] count_o,
  output logic         busy_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
  assign busy_o  = |cnt_q;

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter owner for the RV32I front-end: turns execute's jump/hold
// requests into PC updates, fetch requests and IF/ID + ID/EX flush/stall.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  pc_ctrl_if.slave    bus
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  // A single-cycle flush is fully covered by the jump cycle itself.
  localparam state_e JUMP_STATE = (FLUSH_CYCLES > 1) ? STATE_REDIRECT : STATE_RUN;

  state_e                 state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic                   misalign_q, misalign_d;
  logic                   take_jump, take_hold, handshake;
  logic                   fetch_valid, flush, stall;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic                   flush_busy;

  assign take_jump = bus.jump_en_i && (state_q != STATE_BOOT);
  assign take_hold = bus.hold_flag_i && !bus.jump_en_i &&
                     ((state_q == STATE_RUN) || (state_q == STATE_HOLD));

  pc_ctrl_flush_counter #(.W(FLUSH_CNT_W)) u_flush_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (take_jump),
    .load_val_i (FLUSH_RELOAD),
    .count_o    (flush_cnt),
    .busy_o     (flush_busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= STATE_BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      STATE_BOOT: state_d = STATE_RUN;
      STATE_RUN, STATE_HOLD: begin
        if (take_jump)      state_d = JUMP_STATE;
        else if (take_hold) state_d = STATE_HOLD;
        else                state_d = STATE_RUN;
      end
      STATE_REDIRECT: begin
        if (take_jump)               state_d = JUMP_STATE;
        else if (flush_cnt <= 3'd1)  state_d = STATE_RUN;
        else                         state_d = STATE_REDIRECT;
      end
      default: state_d = STATE_BOOT;
    endcase
  end

  // hold_flag_i is ignored in REDIRECT: the instruction raising it is being flushed.
  always_comb begin
    fetch_valid = 1'b0;
    flush       = 1'b0;
    stall       = 1'b0;
    case (state_q)
      STATE_RUN, STATE_HOLD: begin
        fetch_valid = !take_hold;
        flush       = take_jump;
        stall       = take_hold;
      end
      STATE_REDIRECT: begin
        fetch_valid = 1'b1;
        flush       = take_jump || flush_busy;
      end
      default: ;
    endcase
  end

  assign handshake = fetch_valid && bus.fetch_ready_i;

  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    if (take_jump) begin
      pc_d = align_word(bus.jump_addr_i);
      if (bus.jump_addr_i[1:0] != 2'b00)
        misalign_d = 1'b1;
    end else if (handshake) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.fetch_valid_o = fetch_valid;
  assign bus.flush_o       = flush;
  assign bus.stall_o       = stall;
  assign bus.misalign_o    = misalign_q;

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Front-end control block for the single-issue RV32I pipeline.
- Sits on the receiving end of the execute stage's control outputs (jump address, jump enable, hold flag) and owns the program counter.
- Drives the instruction-fetch request, the flush for the IF/ID and ID/EX pipeline registers, and the pipeline stall.
- Execute issues redirect/hold requests; pc_ctrl turns them into cycle-accurate PC updates and pipeline bubbles.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, number of cycles flush_o stays asserted after a taken jump; legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- jump_addr_i  input  32  redirect target from execute.
- jump_en_i  input  1  redirect request from execute; valid in the same cycle it is sampled.
- hold_flag_i  input  1  execute requests a PC/pipeline freeze.
- fetch_ready_i  input  1  instruction memory accepts the current fetch address.
- pc_o  output  32  current fetch address (inst_addr).
- fetch_valid_o  output  1  pc_o is a valid fetch request.
- flush_o  output  1  IF/ID and ID/EX load a NOP (32'h0000_0013) at the next edge.
- stall_o  output  1  IF/ID and ID/EX hold their contents at the next edge.
- misalign_o  output  1  sticky flag: a jump target with jump_addr_i[1:0] != 0 was received.

Behaviour:
- Reset (async assert, sync deassert handled upstream) sets:
  - pc_o=RESET_PC, state=BOOT, fetch_valid_o=0, flush_o=0, stall_o=0, misalign_o=0.
  - Flush counter = 0.
- Reset asserted mid-operation aborts any REDIRECT/HOLD immediately; no partial flush count survives.
- States: BOOT, RUN, REDIRECT, HOLD; state register is 2 bits.
- BOOT:
  - Lasts exactly one cycle after reset release; fetch_valid_o=0.
  - Next state RUN; pc unchanged.
- RUN:
  - fetch_valid_o=1.
  - pc <= pc+4 only when fetch_valid_o && fetch_ready_i. Otherwise pc is held, with no stall_o; the memory wait is invisible to the pipeline registers.
  - pc wraps 32'hFFFF_FFFC -> 32'h0000_0000 (mod 2^32).
- Priority, evaluated every cycle in RUN/HOLD: rst > jump_en_i > hold_flag_i > normal increment.
- Taken jump (jump_en_i=1 in RUN or HOLD):
  - pc <= {jump_addr_i[31:2],2'b00} at the next edge, regardless of fetch_ready_i.
  - If jump_addr_i[1:0] != 0, set misalign_o=1 at the same edge; it is cleared only by rst.
  - flush_o=1 combinationally in the jump cycle.
  - Enter REDIRECT with counter = FLUSH_CYCLES-1.
- REDIRECT:
  - flush_o=1 while counter != 0; decrement each cycle; at 0 return to RUN with flush_o=0.
  - fetch_valid_o=1; pc increments on handshake as in RUN.
  - A new jump_en_i restarts the count and reloads pc.
  - hold_flag_i is ignored here: its source instruction is being flushed.
  - Total flush length per jump = FLUSH_CYCLES cycles including the jump cycle. With FLUSH_CYCLES=1, REDIRECT is skipped and the next state is RUN.
- HOLD:
  - Entered from RUN when hold_flag_i=1 and jump_en_i=0.
  - stall_o=1 combinationally while hold_flag_i=1 in RUN or HOLD.
  - pc frozen; fetch_valid_o=0.
  - Leave to RUN the first cycle hold_flag_i=0; that cycle has stall_o=0 and fetch_valid_o=1.
  - Simultaneous jump_en_i and hold_flag_i: the jump wins, stall_o=0, flush_o=1.
- flush_o and stall_o are never both 1 in the same cycle.
- Latency: jump sampled at edge N gives the new pc_o visible after edge N; the first redirected fetch is presented in cycle N+1.

Decomposition:
- Shared package/defines file:
  - State encodings: STATE_BOOT=2'd0, STATE_RUN=2'd1, STATE_REDIRECT=2'd2, STATE_HOLD=2'd3.
  - NOP encoding 32'h0000_0013.
  - Default reset PC.
- One natural sub-module: flush_counter (loadable 3-bit down-counter with busy output), instantiated once.

Test Plan:
- Reset/boot: assert rst mid-cycle with RESET_PC=32'h100 -> pc_o=32'h100 immediately, fetch_valid_o=0 for one cycle after release, then pc_o=32'h104 after the first handshake.
- Backpressure: fetch_ready_i low for 3 cycles at pc_o=32'h10 -> pc_o stays 32'h10, stall_o=0; when ready rises, pc_o becomes 32'h14.
- Taken jump: jump_en_i=1, jump_addr_i=32'h200 with FLUSH_CYCLES=2 -> flush_o high for exactly 2 cycles, pc_o=32'h200 next cycle, misalign_o=0.
- Misaligned jump: jump_addr_i=32'h202 -> pc_o=32'h200, misalign_o=1 and stays 1 across later jumps until rst.
- Hold: hold_flag_i=1 for 4 cycles at pc_o=32'h40 -> stall_o=1 and fetch_valid_o=0 for 4 cycles, pc_o=32'h40; resumes at 32'h44 after the handshake.
- Collisions: jump_en_i and hold_flag_i together -> flush_o=1, stall_o=0, pc_o=jump target. A second jump during REDIRECT restarts the flush count. pc_o=32'hFFFF_FFFC with a handshake wraps to 32'h0.
